// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access and write-back pipeline stage
//
// Drives a handshaked data-memory port, aligns and extends load data, flags
// misaligned and timed-out accesses, stalls upstream while an access is
// outstanding, and holds the MEM/WB register feeding the register file.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   valid_mem .. rd_addr_mem         EX/MEM register contents
//   dmem_req/we/addr/wdata/be        data-memory request side
//   dmem_ack, dmem_rdata             data-memory response side
//   stall_mem                        freeze IF..EX/MEM this cycle
//   wb_reg_write_en/rd_addr/rd_data  register-file write port
//   misaligned_exc, bus_error        one-cycle exception pulses
//   exc_addr                         faulting address for either pulse
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_mem,
    input  logic        reg_write_en_mem,
    input  logic        MemtoReg_mem,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic [4:0]  rd_addr_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        wb_reg_write_en,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_rd_data,
    output logic        misaligned_exc,
    output logic        bus_error,
    output logic [31:0] exc_addr
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state;
    logic [7:0]  wait_cnt;

    logic        mem_op;
    logic        addr_bad;
    logic        misaligned;
    logic        timeout_abort;
    logic        complete;
    logic [1:0]  off;
    logic [31:0] byte_word;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign off       = alu_result_mem[1:0];
    assign mem_op    = valid_mem & (MemRead_mem | MemWrite_mem);
    assign dmem_addr = {alu_result_mem[31:2], 2'b00};

    always_comb begin
        addr_bad = 1'b0;
        case (funct3_mem[1:0])
            2'b01:   addr_bad = off[0];
            2'b10:   addr_bad = |off;
            default: addr_bad = 1'b0;
        endcase
    end

    // Misalignment is only judged on entry; in WAIT the access is already known good.
    assign misaligned    = (state == S_IDLE) & mem_op & addr_bad;
    assign dmem_req      = ((state == S_IDLE) & mem_op & ~addr_bad) | (state == S_WAIT);
    assign timeout_abort = (state == S_WAIT) & ~dmem_ack & (wait_cnt == 8'(TIMEOUT - 1));
    assign stall_mem     = dmem_req & ~dmem_ack & ~timeout_abort;
    assign complete      = valid_mem & (mem_op ? (dmem_req & dmem_ack) : 1'b1);

    // A store takes priority when both read and write are flagged.
    always_comb begin
        dmem_we    = MemWrite_mem;
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_data_mem;
        if (MemWrite_mem) begin
            case (funct3_mem[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{rs2_data_mem[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << off;
                    dmem_wdata = {2{rs2_data_mem[15:0]}};
                end
                2'b10:   dmem_be = 4'b1111;
                default: dmem_be = 4'b0000;
            endcase
        end
    end

    assign byte_word = dmem_rdata >> {off, 3'b000};
    assign half_sel  = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = 32'd0;
        case (funct3_mem)
            3'b000:  load_data = {{24{byte_word[7]}}, byte_word[7:0]};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = dmem_rdata;
            3'b100:  load_data = {24'd0, byte_word[7:0]};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dmem_req && !dmem_ack) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                default: begin
                    if (dmem_ack || timeout_abort) begin
                        state    <= S_IDLE;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg_write_en <= 1'b0;
            wb_rd_addr      <= 5'd0;
            wb_rd_data      <= 32'd0;
            misaligned_exc  <= 1'b0;
            bus_error       <= 1'b0;
            exc_addr        <= 32'd0;
        end else begin
            wb_reg_write_en <= complete & reg_write_en_mem & (rd_addr_mem != 5'd0);
            if (complete) begin
                wb_rd_addr <= rd_addr_mem;
                wb_rd_data <= MemtoReg_mem ? load_data : alu_result_mem;
            end
            misaligned_exc <= misaligned;
            bus_error      <= timeout_abort;
            if (misaligned || timeout_abort) begin
                exc_addr <= alu_result_mem;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        valid_mem, reg_write_en_mem, MemtoReg_mem, MemRead_mem, MemWrite_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_result_mem, rs2_data_mem;
    logic [4:0]  rd_addr_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_mem, wb_reg_write_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        misaligned_exc, bus_error;
    logic [31:0] exc_addr;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .valid_mem(valid_mem), .reg_write_en_mem(reg_write_en_mem),
        .MemtoReg_mem(MemtoReg_mem), .MemRead_mem(MemRead_mem),
        .MemWrite_mem(MemWrite_mem), .funct3_mem(funct3_mem),
        .alu_result_mem(alu_result_mem), .rs2_data_mem(rs2_data_mem),
        .rd_addr_mem(rd_addr_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem),
        .wb_reg_write_en(wb_reg_write_en), .wb_rd_addr(wb_rd_addr),
        .wb_rd_data(wb_rd_data),
        .misaligned_exc(misaligned_exc), .bus_error(bus_error), .exc_addr(exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // kind: 0 = register write, 1 = misaligned, 2 = bus error
    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] w);
        logic [7:0]  by;
        logic [15:0] hw;
        by = w[8*o +: 8];
        hw = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return 32'($signed(by));
            3'b001:  return 32'($signed(hw));
            3'b010:  return w;
            3'b100:  return {24'd0, by};
            3'b101:  return {16'd0, hw};
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: every registered output event must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_reg_write_en || misaligned_exc || bus_error) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'd0, wb_reg_write_en, misaligned_exc, bus_error}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                case (e.kind)
                    0: begin
                        chk("wb_en", wb_reg_write_en, 1);
                        chk("wb_rd", wb_rd_addr, e.rd);
                        chk("wb_data", wb_rd_data, e.val);
                        chk("wb_no_exc", {misaligned_exc, bus_error}, 0);
                    end
                    1: begin
                        chk("mis_pulse", misaligned_exc, 1);
                        chk("mis_no_wb", wb_reg_write_en, 0);
                        chk("mis_addr", exc_addr, e.val);
                    end
                    default: begin
                        chk("berr_pulse", bus_error, 1);
                        chk("berr_no_wb", wb_reg_write_en, 0);
                        chk("berr_addr", exc_addr, e.val);
                    end
                endcase
            end
        end
    end

    // Issue one instruction; w is the cycle index at which memory acks (beyond TO = never).
    task automatic run(input logic v, input logic rw, input logic mtr, input logic mr,
                       input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd, input int w,
                       input logic [31:0] rdata);
        logic       mop;
        logic       misal;
        logic [1:0] o;
        ev_t        e;
        valid_mem = v; reg_write_en_mem = rw; MemtoReg_mem = mtr;
        MemRead_mem = mr; MemWrite_mem = mw; funct3_mem = f3;
        alu_result_mem = alu; rs2_data_mem = rs2; rd_addr_mem = rd;
        o     = alu[1:0];
        mop   = v & (mr | mw);
        misal = (f3[1:0] == 2'b01 && o[0]) || (f3[1:0] == 2'b10 && o != 2'b00);
        if (mop && !misal) begin
            for (int i = 0; i <= TO; i++) begin
                dmem_ack   = (i == w);
                dmem_rdata = (i == w) ? rdata : $urandom;
                @(negedge clk);
                chk("req_hi", dmem_req, 1);
                chk("stall", stall_mem, (i != w) && (i != TO));
                chk("addr", dmem_addr, {alu[31:2], 2'b00});
                if (i == 0) begin
                    chk("we", dmem_we, mw);
                    if (mw) begin
                        int sz;
                        int base;
                        sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
                        base = (sz == 4) ? 0 : int'(o);
                        for (int b = 0; b < 4; b++) begin
                            chk("st_be", dmem_be[b], (b >= base) && (b < base + sz));
                            if (b >= base && b < base + sz)
                                chk("st_lane", dmem_wdata[8*b +: 8], rs2[8*(b-base) +: 8]);
                        end
                    end else begin
                        chk("ld_be", dmem_be, 4'b1111);
                    end
                end
                @(posedge clk); #1;
                if (i == w) begin
                    if (!mw && rw && rd != 0) begin
                        e.kind = 0; e.rd = rd; e.val = mtr ? load_val(f3, o, rdata) : alu;
                        exp_q.push_back(e);
                    end
                    break;
                end
                if (i == TO) begin
                    e.kind = 2; e.rd = 0; e.val = alu;
                    exp_q.push_back(e);
                    break;
                end
            end
        end else begin
            dmem_ack   = 1'($urandom);
            dmem_rdata = $urandom;
            @(negedge clk);
            chk("req_lo", dmem_req, 0);
            chk("stall_lo", stall_mem, 0);
            @(posedge clk); #1;
            if (mop) begin
                e.kind = 1; e.rd = 0; e.val = alu;
                exp_q.push_back(e);
            end else if (v && rw && rd != 0) begin
                e.kind = 0; e.rd = rd; e.val = alu;
                exp_q.push_back(e);
            end
        end
        dmem_ack = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wb_en"}, wb_reg_write_en, 0);
        chk({tag, "_wb_rd"}, wb_rd_addr, 0);
        chk({tag, "_wb_data"}, wb_rd_data, 0);
        chk({tag, "_mis"}, misaligned_exc, 0);
        chk({tag, "_berr"}, bus_error, 0);
        chk({tag, "_exc_addr"}, exc_addr, 0);
        chk({tag, "_req"}, dmem_req, 0);
        chk({tag, "_stall"}, stall_mem, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        valid_mem = 0; reg_write_en_mem = 0; MemtoReg_mem = 0; MemRead_mem = 0;
        MemWrite_mem = 0; funct3_mem = 0; alu_result_mem = 0; rs2_data_mem = 0;
        rd_addr_mem = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run(1, 1, 1, 1, 0, 3'b010, 32'h100, 0, 5'd5, 0, 32'hDEADBEEF);
        run(1, 1, 1, 1, 0, 3'b000, 32'h103, 0, 5'd6, 0, 32'h80FF0000);
        run(1, 1, 1, 1, 0, 3'b100, 32'h103, 0, 5'd6, 1, 32'h80FF0000);
        run(1, 0, 0, 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 3, 0);
        run(1, 1, 1, 1, 0, 3'b010, 32'h101, 0, 5'd9, 0, 0);
        run(1, 1, 1, 1, 0, 3'b010, 32'h200, 0, 5'd8, 100, 0);
        run(1, 1, 0, 0, 0, 3'b000, 32'h2A, 0, 5'd7, 0, 0);

        // Reset arriving while the FSM sits in WAIT, followed by a stray ack.
        valid_mem = 1; reg_write_en_mem = 1; MemtoReg_mem = 1; MemRead_mem = 1;
        MemWrite_mem = 0; funct3_mem = 3'b010; alu_result_mem = 32'h300; rd_addr_mem = 5'd4;
        dmem_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; valid_mem = 0;
        @(posedge clk); #1;
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk_zero_outputs("midwait_rst");
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk_zero_outputs("late_ack");
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            int          sel;
            int          w;
            logic [2:0]  f3;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            w   = ($urandom_range(0, 7) == 0) ? $urandom_range(TO + 1, TO + 3) : $urandom_range(0, TO);
            a   = $urandom;
            if (sel < 4) begin
                f3 = 3'($urandom_range(0, 7));
                run(1, 1, 1, 1, 0, f3, a, 0, 5'($urandom), w, $urandom);
            end else if (sel < 6) begin
                f3 = 3'($urandom_range(0, 2));
                run(1, 0, 0, 1'($urandom), 1, f3, a, $urandom, 5'($urandom), w, 0);
            end else if (sel < 9) begin
                run(1, 1'($urandom), 0, 0, 0, 3'($urandom), a, $urandom, 5'($urandom), 0, 0);
            end else begin
                run(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), a, $urandom,
                    5'($urandom), 0, 0);
            end
        end

        valid_mem = 0;
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access and write-back stage of the 5-stage pipeline. It sits directly downstream of ex_mem_reg. It drives a handshaked data-memory port with byte lanes, aligns and sign-extends load data, and detects misaligned and timed-out accesses. It stalls the upstream pipeline while an access is outstanding and holds the MEM/WB register, whose outputs drive the register-file write port in id_stage.

Parameters:
TIMEOUT, 16, maximum cycles spent in WAIT before the access is aborted with bus_error (legal range 2..255).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_mem  in  1  EX/MEM holds a real instruction (0 = bubble)
reg_write_en_mem  in  1  instruction writes rd
MemtoReg_mem  in  1  write-back source: 1 = load data, 0 = ALU result
MemRead_mem  in  1  load
MemWrite_mem  in  1  store
funct3_mem  in  3  access size/sign (RV32I encoding)
alu_result_mem  in  32  effective address / ALU result
rs2_data_mem  in  32  store data
rd_addr_mem  in  5  destination register
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, {alu_result_mem[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete; rdata is valid in the same cycle
dmem_rdata  in  32  read word
stall_mem  out  1  freeze IF..EX/MEM this cycle
wb_reg_write_en  out  1  register-file write enable
wb_rd_addr  out  5  register-file write address
wb_rd_data  out  32  register-file write data
misaligned_exc  out  1  one-cycle pulse: misaligned access
bus_error  out  1  one-cycle pulse: access timed out
exc_addr  out  32  faulting address, valid with either pulse

Behaviour:
- mem_op = valid_mem & (MemRead_mem | MemWrite_mem). If both MemRead_mem and MemWrite_mem are set, the access is treated as a store.
- Misaligned conditions:
  - halfword access (funct3[1:0]=01) with addr[0]=1
  - word access (funct3[1:0]=10) with addr[1:0]!=0
- A misaligned access:
  - issues no request and does not stall
  - next cycle: misaligned_exc=1 and exc_addr=address
  - the MEM/WB slot is a bubble (wb_reg_write_en=0)
- FSM states: IDLE and WAIT.
  - dmem_req = (IDLE & mem_op & aligned) | WAIT, combinational.
  - IDLE, request issued, dmem_ack=1 → access completes this cycle (zero-wait), no stall, stay IDLE.
  - IDLE, request issued, dmem_ack=0 → go to WAIT, clear the wait counter.
  - WAIT, dmem_ack=1 → complete, go to IDLE.
  - WAIT, counter reaches TIMEOUT-1 without ack → abort: next cycle bus_error=1, exc_addr=address, bubble written; go to IDLE.
  - dmem_ack while dmem_req=0 is ignored.
- stall_mem = dmem_req & ~dmem_ack & ~timeout_abort. The upstream stage holds all EX/MEM inputs stable while stall_mem=1.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}
  - SH: be = 0011 << addr[1:0], wdata = {2{rs2[15:0]}}
  - SW: be = 1111, wdata = rs2
- For loads, dmem_be=1111 and dmem_we=0.
- Load extraction from dmem_rdata:
  - byte lane = addr[1:0]; halfword = addr[1] ? upper half : lower half
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through
  - unsupported funct3 values (011, 11x) return 0
- MEM/WB register:
  - Updates every cycle.
  - When an instruction completes (non-memory op, or access acked):
    - wb_reg_write_en = valid_mem & reg_write_en_mem & (rd!=0)
    - wb_rd_addr = rd
    - wb_rd_data = MemtoReg ? load_data : alu_result
  - While stalled, on exception, or on a bubble: wb_reg_write_en=0, address and data hold their last value.
  - Latency is 1 cycle from completion to the write-back outputs.
- Reset, including mid-access in WAIT:
  - next edge: state=IDLE, counter=0
  - wb_reg_write_en=0, wb_rd_addr=0, wb_rd_data=0
  - misaligned_exc=0, bus_error=0, exc_addr=0
  - a late ack arriving after reset is ignored

Test Plan:
- LW addr 0x100, memory returns 0xDEADBEEF with zero-wait ack, rd=5 → no stall; next cycle wb_reg_write_en=1, wb_rd_addr=5, wb_rd_data=0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000; then LBU same address → wb_rd_data=0xFFFFFF80, then 0x00000080.
- SH addr 0x102, rs2=0x1234ABCD, ack after 3 cycles → dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, stall_mem high for exactly 3 cycles, wb_reg_write_en=0.
- LW addr 0x101 → dmem_req never asserted, no stall; next cycle misaligned_exc=1, exc_addr=0x101, no register write.
- TIMEOUT=4, load never acked → stall for 4 cycles; next cycle bus_error=1, FSM back in IDLE; a following ADD to rd=7 (alu_result 0x2A) writes 0x2A.
- rst asserted while in WAIT, then dmem_ack asserted a cycle later → all outputs 0, no write-back, dmem_req=0 after reset.
